// File: rtl/compare_sweep.sv
// compare_sweep: walks a 9-bit index over every 3x3-bit triple {a,b,c}, waits SETTLE cycles per triple, counts comparator ones; define COMPARE_SWEEP_STREAM_EN to add a valid/ready stream of every sample (ports: clk, rst, start, a, b, c, cmp_out, busy, done, ones_cnt, smp_valid, smp_ready, smp_data)
module compare_sweep #(
  parameter int SETTLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [2:0] a,
  output logic [2:0] b,
  output logic [2:0] c,
  input  logic       cmp_out,
  output logic       busy,
  output logic       done,
  output logic [9:0] ones_cnt,
  output logic       smp_valid,
  input  logic       smp_ready,
  output logic [9:0] smp_data
);
  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    SAMPLE,
`ifdef COMPARE_SWEEP_STREAM_EN
    EMIT,
`endif
    DONE
  } state_t;
  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);
  state_t     state, state_n;
  logic [8:0] idx, idx_n;
  logic [3:0] cnt, cnt_n;
  logic [9:0] ones_n;
  logic       adv;
  assign a = idx[8:6];
  assign b = idx[5:3];
  assign c = idx[2:0];
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    idx_n = idx;
    cnt_n = cnt;
    ones_n = ones_cnt;
    adv = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = WAIT;
        idx_n = '0;
        ones_n = '0;
        cnt_n = RELOAD;
      end
      WAIT: if (cnt == 4'd0) state_n = SAMPLE; else cnt_n = cnt - 4'd1;
      SAMPLE: begin
        ones_n = ones_cnt + {9'd0, cmp_out};
`ifdef COMPARE_SWEEP_STREAM_EN
        state_n = EMIT;
`else
        adv = 1'b1;
`endif
      end
`ifdef COMPARE_SWEEP_STREAM_EN
      EMIT: adv = smp_ready;
`endif
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // idx stops at 511 so the last triple stays on a/b/c after the sweep
    if (adv) begin
      if (idx == 9'd511) state_n = DONE;
      else begin
        idx_n = idx + 9'd1;
        cnt_n = RELOAD;
        state_n = WAIT;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      ones_cnt <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
      ones_cnt <= ones_n;
    end
  end
`ifdef COMPARE_SWEEP_STREAM_EN
  assign smp_valid = state == EMIT;
  always_ff @(posedge clk) begin
    if (rst) smp_data <= '0;
    else if (state == SAMPLE) smp_data <= {a, b, c, cmp_out};
  end
`else
  logic unused_ready;
  assign unused_ready = smp_ready;
  assign smp_valid = 1'b0;
  assign smp_data = '0;
`endif
endmodule
